axi_keypad_scanner: RTL and testbench
=====================================

// Module: axi_keypad_scanner
// PURPOSE
//  Parametrised successor to the 4x4 keypad IP: AXI4-Lite slave that scans a ROWS x COLS matrix,
//  debounces every key, queues press/release events in a FIFO and raises a level interrupt.
//  Sits behind the PS/MicroBlaze AXI interconnect; rows/cols go to package pins.
// PARAMETERS
//  ROWS            4     matrix rows, 1..16
//  COLS            4     matrix columns, 1..16
//  DEBOUNCE_SCANS  4     consecutive identical full-scan samples needed to accept a key change
//  FIFO_DEPTH      8     event FIFO depth, power of two, 2..256
//  DEFAULT_DIV     1000  reset value of DIV (cycles per column)
//  C_S00_AXI_DATA_WIDTH 32 ; C_S00_AXI_ADDR_WIDTH 4
// PORTS
//  s00_axi_aclk     in   1   single clock
//  s00_axi_aresetn  in   1   asynchronous, active-low reset
//  s00_axi_aw{addr,prot,valid,ready}  in/in/in/out  4/3/1/1   write address channel
//  s00_axi_w{data,strb,valid,ready}   in/in/in/out  32/4/1/1  write data channel
//  s00_axi_b{resp,valid,ready}        out/out/in    2/1/1     write response
//  s00_axi_ar{addr,prot,valid,ready}  in/in/in/out  4/3/1/1   read address channel
//  s00_axi_r{data,resp,valid,ready}   out/out/out/in 32/2/1/1 read data
//  row_in           in   ROWS  raw row inputs, active-low (key pressed = 0), asynchronous
//  col_out          out  COLS  column drive, active-low one-hot, all-ones when idle
//  irq              out  1     level interrupt, registered
// BEHAVIOUR
//  Reset: all outputs 0 except col_out=all-ones; CTRL=0, DIV=DEFAULT_DIV, FIFO empty, OVF=0, keys released.
//  Registers (byte addr): 0x0 CTRL [0]EN [1]IRQ_EN [2]FLUSH (write-1 self-clearing, reads 0)
//   0x4 STATUS [0]NOT_EMPTY [1]FULL [2]OVF (sticky, W1C) [15:8]COUNT ; 0x8 EVENT (read pops)
//   0xC DIV [15:0]; writes <2 store 2. Unmapped read -> 0; unmapped/RO write ignored; WSTRB ignored.
//  AXI: resp always OKAY. AW and W accepted together (both valid, no write outstanding); BVALID held
//   until BREADY. ARREADY pulses one cycle on accept; RVALID next cycle, held until RREADY; one read outstanding.
//  EVENT word: [31]VALID [8]PRESSED [7:4]row [3:0]col. Pop on AR handshake; empty FIFO -> 0x0, no pop.
//  Scan: row_in 2-flop synchronised. EN=1: col_out drives column c low for DIV cycles; rows sampled on
//   the last cycle of each column period; c wraps COLS-1 -> 0, one full scan = COLS*DIV cycles.
//  Debounce: per key, counter increments each full scan the sample differs from the accepted state,
//   clears when it matches; reaching DEBOUNCE_SCANS flips state and pushes one event.
//  Multiple keys accepted in one scan push in ascending row*COLS+col order, one per cycle.
//  FIFO full on push: event dropped, OVF set. Pop and push same cycle when full: both succeed, no OVF.
//  FLUSH and push same cycle: flush wins, event lost, OVF unchanged. FLUSH clears FIFO, not OVF.
//  EN 1->0: col_out all-ones next cycle, scan index and debounce counters cleared, accepted states
//   forced released without events; FIFO contents kept.
//  irq = IRQ_EN & (NOT_EMPTY | OVF), one-cycle register latency.
//  Reset asserted mid-scan/mid-transaction: immediate return to reset values, AXI handshake abandoned.
// STRUCTURE
//  Package axi_keypad_pkg: register offsets, CTRL/STATUS bit indices, kp_event_t packed struct
//   {pressed,row[3:0],col[3:0]}, DIV_MIN=2.
//  Sub-module kp_event_fifo (DEPTH, WIDTH=9): sync FIFO, push/pop/flush, full/empty/count.
//  Top holds AXI-Lite slave, register file, scan counter, debounce array, event arbiter.
// TESTING
//  Reset then read 0x0/0x4/0xC -> 0x0, 0x0, DEFAULT_DIV; col_out=4'hF, irq=0.
//  DIV=4, EN=1, hold key(1,2) low 5 scans -> one event 0x8000_0112 at 0x8; release -> 0x8000_0012.
//  Key bounce shorter than DEBOUNCE_SCANS-1 scans -> no event, STATUS NOT_EMPTY stays 0.
//  9 accepted events, FIFO_DEPTH=8 -> STATUS=0x0000_0807 (count 8, OVF, FULL, NOT_EMPTY); W1C 0x4 -> OVF 0.
//  IRQ_EN=1 with one event -> irq=1; read 0x8 -> irq=0 two cycles after pop; read empty -> 0x0.
//  Write DIV=0 -> reads 2; EN cleared mid-scan -> col_out all-ones next cycle; reset mid-write -> BVALID 0.

Source files
------------

// File: rtl/axi_keypad_pkg.sv
// Shared definitions for the AXI4-Lite keypad scanner:
// register map, bit positions and the event record.
package axi_keypad_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_EVENT  = 4'h8;
    localparam logic [3:0] REG_DIV    = 4'hC;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef struct packed {
        logic       pressed;
        logic [3:0] row;
        logic [3:0] col;
    } kp_event_t;

endpackage

// File: rtl/kp_event_fifo.sv
// Synchronous event FIFO with flush; flush overrides push and pop,
// and a push into a full FIFO succeeds only alongside a pop.
module kp_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axi_keypad_scanner.sv
// AXI4-Lite keypad scanner: column scan, per-key debounce,
// press/release event FIFO and level interrupt.
module axi_keypad_scanner
    import axi_keypad_pkg::*;
#(
    parameter int ROWS                 = 4,
    parameter int COLS                 = 4,
    parameter int DEBOUNCE_SCANS       = 4,
    parameter int FIFO_DEPTH           = 8,
    parameter int DEFAULT_DIV          = 1000,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [ROWS-1:0]                   row_in,
    output logic [COLS-1:0]                   col_out,
    output logic                              irq
);

    localparam int N   = ROWS * COLS;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DCW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);

    logic clk;
    logic rst_n;
    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    logic        en_q, irq_en_q, ovf_q, irq_q;
    logic [15:0] div_q;
    logic        bvalid_q, arready_q, rvalid_q;
    logic [31:0] rdata_q, rd_word;

    logic [ROWS-1:0] row_s1_q, row_s2_q;
    logic [15:0]     div_cnt_q;
    logic [CW-1:0]   col_q;
    logic            scan_done_q, col_last, col_wrap;

    logic [N-1:0]   samp_q, samp_d;
    logic [N-1:0]   key_q, key_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [DCW-1:0] dcnt_q [N];
    logic [DCW-1:0] dcnt_d [N];

    logic [N-1:0] sel_oh;
    logic         push;
    kp_event_t    ev;

    logic         wr_en, rd_en, flush, pop, ovf_set;
    logic         aw_ctrl, aw_status, aw_div;
    logic         fifo_full, fifo_empty;
    logic [8:0]   fifo_rdata;
    logic [FAW:0] fifo_count;
    logic [7:0]   cnt8;

    logic unused;
    assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                      s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                      s00_axi_wdata[31:16]};

    assign wr_en     = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
    assign rd_en     = arready_q & s00_axi_arvalid;
    assign aw_ctrl   = s00_axi_awaddr[3:2] == REG_CTRL[3:2];
    assign aw_status = s00_axi_awaddr[3:2] == REG_STATUS[3:2];
    assign aw_div    = s00_axi_awaddr[3:2] == REG_DIV[3:2];
    assign flush     = wr_en & aw_ctrl & s00_axi_wdata[CTRL_FLUSH];
    assign pop       = rd_en & (s00_axi_araddr[3:2] == REG_EVENT[3:2]);
    assign ovf_set   = push & fifo_full & ~pop & ~flush;

    assign s00_axi_awready = wr_en;
    assign s00_axi_wready  = wr_en;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign irq             = irq_q;

    assign cnt8 = (fifo_count > (FAW+1)'(255)) ? 8'hFF : 8'(fifo_count);

    always_comb begin
        rd_word = '0;
        unique case (s00_axi_araddr[3:2])
            REG_CTRL[3:2]:   rd_word = {30'd0, irq_en_q, en_q};
            REG_STATUS[3:2]: rd_word = {16'd0, cnt8, 5'd0, ovf_q,
                                        fifo_full, ~fifo_empty};
            REG_EVENT[3:2]:  rd_word = fifo_empty ? 32'd0
                                       : {1'b1, 22'd0, fifo_rdata};
            REG_DIV[3:2]:    rd_word = {16'd0, div_q};
            default:         rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            div_q     <= 16'(DEFAULT_DIV);
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_en) begin
                unique case (1'b1)
                    aw_ctrl: begin
                        en_q     <= s00_axi_wdata[CTRL_EN];
                        irq_en_q <= s00_axi_wdata[CTRL_IRQ_EN];
                    end
                    aw_div: div_q <= (s00_axi_wdata[15:0] < DIV_MIN)
                                     ? DIV_MIN : s00_axi_wdata[15:0];
                    default: ;
                endcase
            end
            if (ovf_set) ovf_q <= 1'b1;
            else if (wr_en && aw_status && s00_axi_wdata[ST_OVF])
                ovf_q <= 1'b0;
            irq_q <= irq_en_q & (~fifo_empty | ovf_q);
            if (wr_en) bvalid_q <= 1'b1;
            else if (s00_axi_bready) bvalid_q <= 1'b0;
            arready_q <= s00_axi_arvalid & ~arready_q & ~rvalid_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Scan timing: rows are sampled on the last cycle of each column slot
    assign col_last = div_cnt_q >= (div_q - 16'd1);
    assign col_wrap = col_q == CW'(COLS - 1);

    always_comb begin
        col_out = '1;
        for (int c = 0; c < COLS; c++)
            if (en_q && col_q == CW'(c)) col_out[c] = 1'b0;
    end

    always_comb begin
        samp_d = samp_q;
        if (en_q && col_last)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (col_q == CW'(c)) samp_d[r*COLS+c] = ~row_s2_q[r];
        if (!en_q) samp_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q    <= '1;
            row_s2_q    <= '1;
            div_cnt_q   <= '0;
            col_q       <= '0;
            scan_done_q <= 1'b0;
            samp_q      <= '0;
        end else begin
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;
            samp_q   <= samp_d;
            if (!en_q) begin
                div_cnt_q   <= '0;
                col_q       <= '0;
                scan_done_q <= 1'b0;
            end else begin
                scan_done_q <= col_last & col_wrap;
                if (col_last) begin
                    div_cnt_q <= '0;
                    col_q     <= col_wrap ? '0 : col_q + 1'b1;
                end else begin
                    div_cnt_q <= div_cnt_q + 16'd1;
                end
            end
        end
    end

    // Lowest pending key index wins the single push slot each cycle
    always_comb begin
        sel_oh = '0;
        ev     = '0;
        push   = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pend_q[r*COLS+c] && !push) begin
                    push             = 1'b1;
                    sel_oh[r*COLS+c] = 1'b1;
                    ev.pressed       = key_q[r*COLS+c];
                    ev.row           = 4'(r);
                    ev.col           = 4'(c);
                end
    end

    always_comb begin
        key_d  = key_q;
        pend_d = pend_q & ~sel_oh;
        dcnt_d = dcnt_q;
        if (scan_done_q)
            for (int k = 0; k < N; k++)
                if (samp_q[k] != key_q[k]) begin
                    if (dcnt_q[k] == DCW'(DEBOUNCE_SCANS - 1)) begin
                        key_d[k]  = ~key_q[k];
                        pend_d[k] = 1'b1;
                        dcnt_d[k] = '0;
                    end else begin
                        dcnt_d[k] = dcnt_q[k] + DCW'(1);
                    end
                end else begin
                    dcnt_d[k] = '0;
                end
        if (!en_q) begin
            key_d  = '0;
            pend_d = '0;
            for (int k = 0; k < N; k++) dcnt_d[k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            pend_q <= '0;
            for (int k = 0; k < N; k++) dcnt_q[k] <= '0;
        end else begin
            key_q  <= key_d;
            pend_q <= pend_d;
            dcnt_q <= dcnt_d;
        end
    end

    kp_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(kp_event_t))
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (ev),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_axi_keypad_scanner.sv
// Directed self-checking bench for axi_keypad_scanner
// with a simple 4x4 switch-matrix model on row_in/col_out.
module tb_axi_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        irq;

    logic [15:0] keys = '0;
    logic [31:0] rd;
    int          checks = 0;
    int          failures = 0;

    localparam int SCAN = 16;

    always #5 clk = ~clk;

    always_comb begin
        row_in = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    axi_keypad_scanner dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .row_in          (row_in),
        .col_out         (col_out),
        .irq             (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 50) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 50) begin
            @(negedge clk); n++;
        end
        chk("wr_timeout", 32'(n >= 50), 32'd0);
        chk("bresp", 32'(bresp), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        #1 arvalid = 1'b0;
        while (!rvalid && n < 50) begin
            @(negedge clk); n++;
        end
        chk("rd_timeout", 32'(n >= 50), 32'd0);
        d = rdata;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col_out", 32'(col_out), 32'hF);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        rst_n = 1'b1;

        axi_read(4'h0, rd); chk("rst_ctrl", rd, 32'h0);
        axi_read(4'h4, rd); chk("rst_status", rd, 32'h0);
        axi_read(4'hC, rd); chk("rst_div", rd, 32'd1000);

        axi_write(4'hC, 32'd4);
        axi_read(4'hC, rd); chk("div4", rd, 32'd4);
        axi_write(4'h0, 32'h1);
        repeat (5) @(negedge clk);
        chk("col_onehot", 32'($countones(~col_out)), 32'd1);

        keys[6] = 1'b1;
        repeat (6 * SCAN) @(negedge clk);
        axi_read(4'h4, rd); chk("status_one", rd, 32'h0000_0101);
        axi_read(4'h8, rd); chk("ev_press12", rd, 32'h8000_0112);
        axi_read(4'h8, rd); chk("ev_empty0", rd, 32'h0);
        keys[6] = 1'b0;
        repeat (6 * SCAN) @(negedge clk);
        axi_read(4'h8, rd); chk("ev_rel12", rd, 32'h8000_0012);

        keys[6] = 1'b1;
        repeat (SCAN) @(negedge clk);
        keys[6] = 1'b0;
        repeat (6 * SCAN) @(negedge clk);
        axi_read(4'h4, rd); chk("bounce_status", rd, 32'h0);

        axi_write(4'h0, 32'h0);
        keys[4:0] = 5'h1F;
        axi_write(4'h0, 32'h1);
        repeat (7 * SCAN) @(negedge clk);
        keys[3:0] = 4'h0;
        repeat (7 * SCAN) @(negedge clk);
        axi_read(4'h4, rd); chk("ovf_status", rd, 32'h0000_0807);
        axi_write(4'h4, 32'h4);
        axi_read(4'h4, rd); chk("ovf_w1c", rd, 32'h0000_0803);
        axi_read(4'h8, rd); chk("ev_order0", rd, 32'h8000_0100);
        axi_read(4'h8, rd); chk("ev_order1", rd, 32'h8000_0101);
        axi_read(4'h4, rd); chk("status_six", rd, 32'h0000_0601);
        axi_write(4'h0, 32'h5);
        axi_read(4'h4, rd); chk("flush_status", rd, 32'h0);
        axi_read(4'h0, rd); chk("flush_reads0", rd, 32'h1);

        axi_write(4'h0, 32'h3);
        repeat (3) @(negedge clk);
        chk("irq_idle", 32'(irq), 32'd0);
        keys[4] = 1'b0;
        repeat (7 * SCAN) @(negedge clk);
        chk("irq_set", 32'(irq), 32'd1);
        axi_read(4'h8, rd); chk("ev_rel10", rd, 32'h8000_0010);
        chk("irq_lat", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_clr", 32'(irq), 32'd0);
        axi_read(4'h8, rd); chk("ev_empty1", rd, 32'h0);

        axi_write(4'hC, 32'd0);
        axi_read(4'hC, rd); chk("div_min0", rd, 32'd2);
        axi_write(4'hC, 32'd1);
        axi_read(4'hC, rd); chk("div_min1", rd, 32'd2);
        axi_write(4'hC, 32'd4);

        repeat (7) @(negedge clk);
        chk("col_onehot2", 32'($countones(~col_out)), 32'd1);
        axi_write(4'h0, 32'h0);
        chk("en_off_cols", 32'(col_out), 32'hF);

        bready = 1'b0;
        @(negedge clk);
        awaddr = 4'hC; wdata = 32'd9; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_held", 32'(bvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_bvalid2", 32'(bvalid), 32'd0);
        chk("rst_col_out2", 32'(col_out), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        bready = 1'b1;
        axi_read(4'hC, rd); chk("rst_div2", rd, 32'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
